// File: rtl/bennett_clock_gen_if.sv
// Control and rail bundle for bennett_clock_gen. master = sequencer/issue logic,
// slave = the clock generator itself.
interface bennett_clock_gen_if #(
  parameter int WIDTH  = 11,
  parameter int HOLD_W = 4,
  parameter int CNT_W  = 16
);
  // start/continuous act as a request, and busy acts as the inverse of ready.
  // A request is taken only on a rising edge where busy=0 and stall=0.
  // start is ignored while busy=1.
  logic              start;
  logic              continuous;
  logic [HOLD_W-1:0] hold_cycles;
  logic              stall;
  logic              busy;
  logic              Fclk;
  logic              instFlag;
  logic [WIDTH-1:0]  lane_active;
  logic [WIDTH-1:0]  clkn;
  logic [WIDTH-1:0]  clkp;
  logic [CNT_W-1:0]  cycle_count;
  logic [1:0]        dbg_state;

  modport master (
    output start, continuous, hold_cycles, stall,
    input  busy, Fclk, instFlag, lane_active, clkn, clkp, cycle_count, dbg_state
  );

  modport slave (
    input  start, continuous, hold_cycles, stall,
    output busy, Fclk, instFlag, lane_active, clkn, clkp, cycle_count, dbg_state
  );
endinterface

// File: rtl/bennett_clock_gen.sv
// Multi-phase Bennett clock generator: ramps WIDTH rail pairs up, dwells, ramps down.
// Optional BENNETT_XPROP_EN: inactive rails drive X instead of parked 1/0 levels.
module bennett_clock_gen #(
  parameter int WIDTH  = 11,
  parameter int HOLD_W = 4,
  parameter int CNT_W  = 16,
  localparam int LVL_W = $clog2(WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  bennett_clock_gen_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_TOP = LVL_W'(WIDTH);

  state_t            state, state_nxt;
  logic [LVL_W-1:0]  lvl, lvl_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic              fclk_nxt;
  logic              inst_nxt;
  logic              cnt_inc;
  logic [WIDTH-1:0]  mask_nxt;
  logic [WIDTH-1:0]  clkp_nxt;
  logic [WIDTH-1:0]  clkn_nxt;

  function automatic logic [WIDTH-1:0] lane_mask(input logic [LVL_W-1:0] l);
    lane_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lane_mask[i] = (LVL_W'(i) < l);
    end
  endfunction

  always_comb begin
    state_nxt    = state;
    lvl_nxt      = lvl;
    hold_cnt_nxt = hold_cnt;
    fclk_nxt     = 1'b0;
    inst_nxt     = 1'b0;
    cnt_inc      = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.stall && (bus.start || bus.continuous)) begin
          state_nxt    = RAMP_UP;
          lvl_nxt      = LVL_ONE;
          hold_cnt_nxt = bus.hold_cycles;
        end
      end
      RAMP_UP: begin
        if (!bus.stall) begin
          lvl_nxt = lvl + LVL_ONE;
          if (lvl == LVL_TOP - LVL_ONE) begin
            fclk_nxt  = 1'b1;
            state_nxt = (hold_cnt != '0) ? HOLD : RAMP_DOWN;
          end
        end
      end
      HOLD: begin
        // Level stays at WIDTH; leaving on count 1 gives 1+H cycles at full level.
        if (!bus.stall) begin
          hold_cnt_nxt = hold_cnt - HOLD_W'(1);
          if (hold_cnt == HOLD_W'(1)) begin
            state_nxt = RAMP_DOWN;
          end
        end
      end
      RAMP_DOWN: begin
        if (!bus.stall) begin
          lvl_nxt = lvl - LVL_ONE;
          if (lvl == LVL_ONE) begin
            inst_nxt  = 1'b1;
            cnt_inc   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        lvl_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    mask_nxt = lane_mask(lvl_nxt);
    clkp_nxt = '0;
    clkn_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
`ifdef BENNETT_XPROP_EN
      clkp_nxt[i] = mask_nxt[i] ? 1'b1 : 1'bx;
      clkn_nxt[i] = mask_nxt[i] ? 1'b0 : 1'bx;
`else
      clkp_nxt[i] = mask_nxt[i];
      clkn_nxt[i] = ~mask_nxt[i];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      lvl      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      lvl      <= lvl_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // Every output is loaded from next-state values so nothing is combinational.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.busy        <= 1'b0;
      bus.Fclk        <= 1'b0;
      bus.instFlag    <= 1'b0;
      bus.cycle_count <= '0;
      bus.lane_active <= '0;
`ifdef BENNETT_XPROP_EN
      bus.clkp        <= 'x;
      bus.clkn        <= 'x;
`else
      bus.clkp        <= '0;
      bus.clkn        <= '1;
`endif
    end else begin
      bus.busy        <= (state_nxt != IDLE);
      bus.Fclk        <= fclk_nxt;
      bus.instFlag    <= inst_nxt;
      bus.lane_active <= mask_nxt;
      bus.clkp        <= clkp_nxt;
      bus.clkn        <= clkn_nxt;
      if (cnt_inc) begin
        bus.cycle_count <= bus.cycle_count + CNT_W'(1);
      end
    end
  end

  assign bus.dbg_state = state;

endmodule

// File: tb/tb_bennett_clock_gen.sv
// Bench for bennett_clock_gen: a WIDTH=11 and a WIDTH=2/CNT_W=2 instance share one
// stimulus stream and are checked against a phase-index reference model.
module tb_bennett_clock_gen;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, cont, stall;
  logic [3:0] hold;

  always #5 clk = ~clk;

  bennett_clock_gen_if #(.WIDTH(11), .HOLD_W(4), .CNT_W(16)) bus0 ();
  bennett_clock_gen_if #(.WIDTH(2),  .HOLD_W(4), .CNT_W(2))  bus1 ();

  assign bus0.start = start;  assign bus0.continuous = cont;
  assign bus0.stall = stall;  assign bus0.hold_cycles = hold;
  assign bus1.start = start;  assign bus1.continuous = cont;
  assign bus1.stall = stall;  assign bus1.hold_cycles = hold;

  bennett_clock_gen #(.WIDTH(11), .HOLD_W(4), .CNT_W(16)) u_gen11 (
    .clk(clk), .reset(rst_n), .bus(bus0)
  );
  bennett_clock_gen #(.WIDTH(2), .HOLD_W(4), .CNT_W(2)) u_gen2 (
    .clk(clk), .reset(rst_n), .bus(bus1)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [63:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // One Bennett cycle is a phase index t = 0 .. 2W-1+H after the start edge;
  // the level is a piecewise function of t.
  int wd[2] = '{11, 2};
  int cw[2] = '{16, 2};
  bit m_act[2];
  int m_t[2];
  int m_h[2];
  int m_cnt[2];
  bit m_fl[2];
  bit m_in[2];

  function automatic int lvl_of(input int w, input int h, input int t);
    if (t < w)          return t + 1;
    else if (t < w + h) return w;
    else                return 2 * w - 1 + h - t;
  endfunction

  task automatic model_step(input int k);
    m_fl[k] = 1'b0;
    m_in[k] = 1'b0;
    if (!rst_n) begin
      m_act[k] = 1'b0;
      m_t[k]   = 0;
      m_cnt[k] = 0;
    end else if (!m_act[k]) begin
      if (!stall && (start || cont)) begin
        m_act[k] = 1'b1;
        m_t[k]   = 0;
        m_h[k]   = int'(hold);
      end
    end else if (!stall) begin
      m_t[k]++;
      if (m_t[k] == wd[k] - 1) m_fl[k] = 1'b1;
      if (m_t[k] == 2 * wd[k] - 1 + m_h[k]) begin
        m_act[k] = 1'b0;
        m_in[k]  = 1'b1;
        m_cnt[k] = (m_cnt[k] + 1) % (1 << cw[k]);
      end
    end
  endtask

  task automatic check_inst(input int k, input logic busy, input logic fclk, input logic inst,
                            input logic [63:0] lane, input logic [63:0] cp,
                            input logic [63:0] cn, input logic [63:0] cnt);
    int          lv;
    logic [63:0] wmask, mask, ecp, ecn;
    lv    = m_act[k] ? lvl_of(wd[k], m_h[k], m_t[k]) : 0;
    wmask = (64'd1 << wd[k]) - 64'd1;
    mask  = (64'd1 << lv) - 64'd1;
`ifdef BENNETT_XPROP_EN
    ecp = '0;
    ecn = '0;
    for (int i = 0; i < wd[k]; i++) begin
      ecp[i] = mask[i] ? 1'b1 : 1'bx;
      ecn[i] = mask[i] ? 1'b0 : 1'bx;
    end
`else
    ecp = mask;
    ecn = ~mask & wmask;
`endif
    exp_q.push_back(mask);
    check_val($sformatf("u%0d.busy", k),        64'(busy), 64'(m_act[k]));
    check_val($sformatf("u%0d.Fclk", k),        64'(fclk), 64'(m_fl[k]));
    check_val($sformatf("u%0d.instFlag", k),    64'(inst), 64'(m_in[k]));
    check_val($sformatf("u%0d.lane_active", k), lane,      exp_q.pop_front());
    check_val($sformatf("u%0d.clkp", k),        cp,        ecp);
    check_val($sformatf("u%0d.clkn", k),        cn,        ecn);
    check_val($sformatf("u%0d.cycle_count", k), cnt,       64'(m_cnt[k]));
  endtask

  // ---------------- driver ----------------
  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    cyc++;
    check_inst(0, bus0.busy, bus0.Fclk, bus0.instFlag, 64'(bus0.lane_active),
               64'(bus0.clkp), 64'(bus0.clkn), 64'(bus0.cycle_count));
    check_inst(1, bus1.busy, bus1.Fclk, bus1.instFlag, 64'(bus1.lane_active),
               64'(bus1.clkp), 64'(bus1.clkn), 64'(bus1.cycle_count));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cont = 1'b0; stall = 1'b0; hold = 4'd0;
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();

    // single cycle, H=0, with busy-time start pulses and hold changes
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 21; i++) begin
      start = ($urandom_range(0, 2) == 0);
      hold  = 4'($urandom);
      cycle();
    end
    start = 1'b0;
    hold  = 4'd0;
    repeat (25) cycle();

    // continuous with H=3
    hold = 4'd3;
    cont = 1'b1;
    repeat (75) cycle();
    cont = 1'b0;
    repeat (30) cycle();

    // stall for 5 cycles at lvl=6 on the way down (H=0)
    hold  = 4'd0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (15) cycle();
    stall = 1'b1;
    repeat (5) cycle();
    stall = 1'b0;
    repeat (12) cycle();

    // reset at lvl=7 while ramping up
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (6) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    repeat (4) cycle();

    // randomized mix
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) cont = ~cont;
      stall = ($urandom_range(0, 5) == 0);
      hold  = 4'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
